// File: rtl/dice_roll_display.sv
// Dice roll display stage.
// Synchronises and debounces a raw roll button. Each press runs a timed roll
// that animates the displayed digit, then latches a final face and holds it.
// The held face is decoded to an active-high 7-segment pattern.
module dice_roll_display #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ROLL_CYCLES     = 16,
  parameter int STEP_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [5:0] face_in,
  output logic [2:0] face_out,
  output logic [6:0] seg,
  output logic       rolling,
  output logic       result_valid,
  output logic [7:0] roll_count
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] ROLL_LAST = RW'(ROLL_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ROLLING, HOLD} state_t;

  logic          s1, s2, deb, deb_d;
  logic [DW-1:0] cnt;
  logic          press;
  logic          face_valid;

  state_t        state, state_next;
  logic [RW-1:0] roll_timer, roll_timer_next;
  logic [SW-1:0] step_timer, step_timer_next;
  logic [2:0]    face_next;
  logic          result_valid_next;
  logic [7:0]    roll_count_next;

  // Two-flop synchroniser, debounce counter and press-edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      deb_d <= deb;
      if (s2 != deb) begin
        if (cnt == DEB_LAST) begin
          deb <= ~deb;
          cnt <= '0;
        end else begin
          cnt <= cnt + DW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Only the rising edge of the debounced level starts a roll; release is ignored.
  assign press      = deb & ~deb_d;
  assign face_valid = (face_in != 6'd0) && (face_in <= 6'd6);
  assign rolling    = (state == ROLLING);

  // FSM state, roll timers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      roll_timer   <= '0;
      step_timer   <= '0;
      face_out     <= 3'd0;
      result_valid <= 1'b0;
      roll_count   <= 8'd0;
    end else begin
      state        <= state_next;
      roll_timer   <= roll_timer_next;
      step_timer   <= step_timer_next;
      face_out     <= face_next;
      result_valid <= result_valid_next;
      roll_count   <= roll_count_next;
    end
  end

  // Next-state logic: start on press, animate on step boundaries, finish on the last roll cycle.
  always_comb begin
    state_next        = state;
    roll_timer_next   = roll_timer;
    step_timer_next   = step_timer;
    face_next         = face_out;
    result_valid_next = 1'b0;
    roll_count_next   = roll_count;
    case (state)
      IDLE, HOLD: begin
        if (press) begin
          state_next      = ROLLING;
          roll_timer_next = '0;
          step_timer_next = '0;
        end
      end
      ROLLING: begin
        if (roll_timer == ROLL_LAST) begin
          // Final sample wins over any animation step on the same edge.
          if (face_valid) face_next = face_in[2:0];
          state_next        = HOLD;
          roll_timer_next   = '0;
          step_timer_next   = '0;
          result_valid_next = 1'b1;
          roll_count_next   = roll_count + 8'd1;
        end else begin
          roll_timer_next = roll_timer + RW'(1);
          if (step_timer == STEP_LAST) begin
            step_timer_next = '0;
            if (face_valid) face_next = face_in[2:0];
          end else begin
            step_timer_next = step_timer + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Seven-segment decode {g,f,e,d,c,b,a}; blank for 0 and the unused code 7.
  always_comb begin
    seg = 7'h00;
    case (face_out)
      3'd1:    seg = 7'h06;
      3'd2:    seg = 7'h5B;
      3'd3:    seg = 7'h4F;
      3'd4:    seg = 7'h66;
      3'd5:    seg = 7'h6D;
      3'd6:    seg = 7'h7D;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: tb/tb_dice_roll_display.sv
// Scoreboard bench for dice_roll_display: stimulus pushes expected results,
// a monitor pops and compares on every result_valid pulse.
module tb_dice_roll_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [5:0] face_in;
  logic [2:0] face_out;
  logic [6:0] seg;
  logic       rolling;
  logic       result_valid;
  logic [7:0] roll_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [17:0] sb_q[$];      // {face[2:0], seg[6:0], count[7:0]}
  logic [5:0]  fv[16];       // face_in applied on ROLLING edges 1..16
  logic [2:0]  cur_face;     // bench expectation of held face before a roll
  logic [7:0]  cnt_exp;

  dice_roll_display dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .face_in      (face_in),
    .face_out     (face_out),
    .seg          (seg),
    .rolling      (rolling),
    .result_valid (result_valid),
    .roll_count   (roll_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [5:0] v);
    for (int i = 0; i < 16; i++) fv[i] = v;
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got face=%0d seg=%0h count=%0d expected no pulse",
                 face_out, seg, roll_count);
      end else begin
        logic [17:0] e;
        e = sb_q.pop_front();
        chk("result_face", {29'd0, face_out}, {29'd0, e[17:15]});
        chk("result_seg", {25'd0, seg}, {25'd0, e[14:8]});
        chk("result_count", {24'd0, roll_count}, {24'd0, e[7:0]});
        $display("result face=%0d seg=%02h count=%0d", face_out, seg, roll_count);
      end
    end
  end

  // One complete roll: press, check latency, feed fv, track animation, settle.
  task automatic do_roll(input string nm, input logic [2:0] ef, input logic [6:0] es, input bit rebtn);
    logic [2:0] m;
    m = cur_face;
    face_in = fv[0];
    btn = 1'b1;
    repeat (6) tick();
    chk({nm, "_pre_latency"}, {31'd0, rolling}, 32'd0);
    tick();
    chk({nm, "_latency"}, {31'd0, rolling}, 32'd1);
    cnt_exp = cnt_exp + 8'd1;
    sb_q.push_back({ef, es, cnt_exp});
    for (int k = 1; k <= 16; k++) begin
      face_in = fv[k-1];
      if (k == 1) btn = 1'b0;
      if (rebtn && k == 7) btn = 1'b1;
      if (rebtn && k == 14) btn = 1'b0;
      tick();
      if ((k % 2 == 0) && fv[k-1] >= 6'd1 && fv[k-1] <= 6'd6) m = fv[k-1][2:0];
      chk($sformatf("%s_anim_k%0d", nm, k), {29'd0, face_out}, {29'd0, m});
      if (k == 15) chk({nm, "_rolling_k15"}, {31'd0, rolling}, 32'd1);
      if (k == 16) chk({nm, "_rolling_end"}, {31'd0, rolling}, 32'd0);
    end
    cur_face = ef;
    repeat (10) tick();
    chk({nm, "_no_reroll"}, {31'd0, rolling}, 32'd0);
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    btn = 1'b0;
    face_in = 6'd0;
    cur_face = 3'd0;
    cnt_exp = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_face", {29'd0, face_out}, 32'd0);
    chk("reset_seg", {25'd0, seg}, 32'd0);
    chk("reset_rolling", {31'd0, rolling}, 32'd0);
    chk("reset_rv", {31'd0, result_valid}, 32'd0);
    chk("reset_count", {24'd0, roll_count}, 32'd0);
    rst = 1'b0;
    tick();

    // First roll with invalid face throughout: stays blank.
    fill(6'd0);
    do_roll("inv_first", 3'd0, 7'h00, 1'b0);
    // Steady face 3.
    fill(6'd3);
    do_roll("face3", 3'd3, 7'h4F, 1'b0);

    // Short bounce: 3 clocks high never debounces.
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rolling) ok = 1'b0;
    end
    chk("bounce_no_roll", {31'd0, ok}, 32'd1);
    chk("bounce_count", {24'd0, roll_count}, {24'd0, cnt_exp});

    // Animation with 1..6 cycling; a second press mid-roll is ignored.
    for (int i = 0; i < 16; i++) fv[i] = 6'((i % 6) + 1);
    do_roll("anim", 3'd4, 7'h66, 1'b1);

    // Invalid codes mixed in; only even-edge valid sample (5) sticks.
    fill(6'd7);
    fv[4] = 6'd2; fv[5] = 6'd5; fv[9] = 6'd0; fv[11] = 6'd63;
    do_roll("inv_mix", 3'd5, 7'h6D, 1'b0);
    // All invalid: previous face held.
    fill(6'd0);
    do_roll("inv_hold", 3'd5, 7'h6D, 1'b0);
    fill(6'd2);
    do_roll("face2", 3'd2, 7'h5B, 1'b0);
    fill(6'd6);
    fv[15] = 6'd1;
    do_roll("final1", 3'd1, 7'h06, 1'b0);

    // Continue to 256 completed rolls; counter must wrap to 0.
    fill(6'd6);
    while (cnt_exp != 8'd255) do_roll("wrap", 3'd6, 7'h7D, 1'b0);
    do_roll("wrap_last", 3'd6, 7'h7D, 1'b0);
    chk("wrap_count_zero", {24'd0, roll_count}, 32'd0);

    // Async reset mid-roll, button held through release.
    fill(6'd3);
    face_in = 6'd3;
    btn = 1'b1;
    repeat (12) tick();
    chk("mid_roll_active", {31'd0, rolling}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_face", {29'd0, face_out}, 32'd0);
    chk("async_seg", {25'd0, seg}, 32'd0);
    chk("async_rolling", {31'd0, rolling}, 32'd0);
    chk("async_count", {24'd0, roll_count}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cur_face = 3'd0;
    cnt_exp = 8'd0;
    fill(6'd5);
    do_roll("held_reset", 3'd5, 7'h6D, 1'b0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
